parity_scrubber: RTL
====================

Name: parity_scrubber

Overview:
- Background scrub controller for a parity-protected memory (word = data + 1-bit even parity code).
- Walks every address, issues one read at a time over a request/grant/valid interface, and checks each returned word.
- Reports failing addresses and keeps a saturating error count.
- Sits beside the memory arbiter as a low-priority requester. INTERVAL throttles its bandwidth.

Parameters:
- DATA_WIDTH, 8, width of the stored data word.
- DEPTH, 16, number of words scrubbed (addresses 0..DEPTH-1). Must be ≥ 2.
- ADDRESS_WIDTH, $clog2(DEPTH), width of read_address and error_address.
- INTERVAL, 0, idle cycles inserted after each check before the next request.
- COUNT_WIDTH, 8, width of error_count.

Ports:
- clock  input  1  single clock; all logic on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  begin a scrub pass when idle. Ignored while busy.
- continuous  input  1  sampled at end of a pass. 1 = restart at address 0 automatically.
- abort  input  1  stop the scrub (see Behaviour).
- clear_count  input  1  clear error_count.
- busy  output  1  high from the cycle after accepted start until return to IDLE.
- done  output  1  one-cycle pulse after the last address of a pass is checked.
- read_request  output  1  read request to memory/arbiter.
- read_address  output  ADDRESS_WIDTH  address of current request. Stable while read_request=1.
- read_grant  input  1  request accepted this cycle when read_request=1.
- read_valid  input  1  read data returned. At most one per grant, any latency ≥ 1.
- read_data  input  DATA_WIDTH  returned data.
- read_code  input  1  returned parity bit.
- error_valid  output  1  one-cycle pulse: parity error found.
- error_address  output  ADDRESS_WIDTH  address of the most recent error. Holds until the next error.
- error_count  output  COUNT_WIDTH  errors since reset/clear. Saturates at 2^COUNT_WIDTH-1.

Behaviour:
- Reset values: busy=0, done=0, read_request=0, read_address=0, error_valid=0, error_address=0, error_count=0. FSM=IDLE.
- Parity rule: error = read_code != XOR-reduce(read_data). Even parity: all-zero data with code 0 is correct.
- IDLE: start=1 → REQUEST with address 0.
- REQUEST: read_request=1. On read_grant → WAIT.
- WAIT: read_request=0. On read_valid, register data/code → CHECK.
- CHECK (1 cycle): compute parity and update error outputs.
  - Last address (DEPTH-1): pulse done. continuous=1 → REQUEST with address 0 (or PAUSE if INTERVAL>0). Otherwise → IDLE.
  - Other addresses: address+1, → PAUSE if INTERVAL>0, else → REQUEST.
- PAUSE: counter counts INTERVAL cycles, then → REQUEST.
- Throughput at INTERVAL=0 with grant and valid each next cycle: one word per 3 cycles.
- error_valid and error_address update in the cycle after CHECK, i.e. 2 cycles after read_valid.
- Counter update: error_count += 1 unless saturated. clear_count alone → 0. clear_count with an error in the same cycle → 1.
- abort:
  - In REQUEST or PAUSE: → IDLE next cycle; read_request drops; no done.
  - In WAIT: still wait for read_valid, discard the result (no check), then → IDLE. Never leave a read outstanding.
  - In CHECK: this check completes and is reported, then → IDLE.
  - No done pulse on abort.
- Inputs outside their states are ignored: read_grant outside REQUEST, read_valid outside WAIT, start while busy.
- busy drops in the same cycle the FSM enters IDLE.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight read response after reset is ignored (FSM is in IDLE).

Optional Feature:
- Macro: PARITY_SCRUBBER_STOP_ON_ERROR_EN.
- Defined: an error found in CHECK ends the pass. error_valid pulses, error_address updates, then → IDLE without done and regardless of continuous. The error address is preserved for software.
- Undefined: errors are logged and the scrub continues.

Test Plan:
- Setup DEPTH=4, DATA_WIDTH=8, INTERVAL=0. Memory returns correct parity with grant and valid one cycle after each request. start pulse → addresses 0,1,2,3 requested in order; done pulses once; error_count=0; busy=0 afterwards.
- Address 2 holds data 0x01 with code 0 → one error_valid pulse, error_address=2, error_count=1, pass still completes with done. With STOP_ON_ERROR_EN: no done, address 3 never requested.
- continuous=1, all words in error, COUNT_WIDTH=2 → error_count reaches 3 and stays at 3. clear_count asserted in an error cycle → error_count=1.
- Setup INTERVAL=5 and read_grant delayed 3 cycles. Check: exactly 5 idle cycles between each CHECK and the next read_request; read_address stable while waiting for grant.
- abort asserted in WAIT with read_valid 4 cycles later → no error reported even if the word is bad; IDLE one cycle after read_valid; no done.
- resetn asserted during REQUEST → all outputs at reset values immediately. A stray read_valid afterwards has no effect.

Source files
------------

// File: rtl/parity_scrubber.sv
// parity_scrubber: background scrub controller for an even-parity protected memory.
// Optional macro PARITY_SCRUBBER_STOP_ON_ERROR_EN ends a pass at the first parity error.
module parity_scrubber #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int INTERVAL      = 0,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     abort,
  input  logic                     clear_count,
  output logic                     busy,
  output logic                     done,
  output logic                     read_request,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic                     read_grant,
  input  logic                     read_valid,
  input  logic [DATA_WIDTH-1:0]    read_data,
  input  logic                     read_code,
  output logic                     error_valid,
  output logic [ADDRESS_WIDTH-1:0] error_address,
  output logic [COUNT_WIDTH-1:0]   error_count
);
  localparam int PAUSE_WIDTH = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [PAUSE_WIDTH-1:0]   PAUSE_LAST   = PAUSE_WIDTH'(INTERVAL - 1);
  localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX    = {COUNT_WIDTH{1'b1}};
`ifdef PARITY_SCRUBBER_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERROR = 1'b1;
`else
  localparam bit STOP_ON_ERROR = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT, CHECK, PAUSE} state_t;
  localparam state_t AFTER_CHECK = (INTERVAL > 0) ? PAUSE : REQUEST;

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] address_reg, address_next;
  logic [PAUSE_WIDTH-1:0]   pause_reg, pause_next;
  logic [DATA_WIDTH-1:0]    data_reg, data_next;
  logic                     code_reg, code_next;
  logic                     abort_pending_reg, abort_pending_next;
  logic                     done_reg, done_next;
  logic                     error_valid_reg, error_valid_next;
  logic [ADDRESS_WIDTH-1:0] error_address_reg, error_address_next;
  logic [COUNT_WIDTH-1:0]   count_reg, count_next;
  logic                     parity_error, check_error, stop_pass;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= IDLE;
      address_reg       <= '0;
      pause_reg         <= '0;
      data_reg          <= '0;
      code_reg          <= 1'b0;
      abort_pending_reg <= 1'b0;
      done_reg          <= 1'b0;
      error_valid_reg   <= 1'b0;
      error_address_reg <= '0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      address_reg       <= address_next;
      pause_reg         <= pause_next;
      data_reg          <= data_next;
      code_reg          <= code_next;
      abort_pending_reg <= abort_pending_next;
      done_reg          <= done_next;
      error_valid_reg   <= error_valid_next;
      error_address_reg <= error_address_next;
      count_reg         <= count_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    address_next       = address_reg;
    pause_next         = pause_reg;
    data_next          = data_reg;
    code_next          = code_reg;
    abort_pending_next = abort_pending_reg;
    done_next          = 1'b0;
    error_valid_next   = 1'b0;
    error_address_next = error_address_reg;
    count_next         = count_reg;
    parity_error       = code_reg != ^data_reg;
    check_error        = 1'b0;
    stop_pass          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        abort_pending_next = 1'b0;
        if (start) begin
          state_next   = REQUEST;
          address_next = '0;
        end
      end
      REQUEST: begin
        // A grant coinciding with abort still drains its response before going idle.
        if (read_grant) begin
          state_next         = WAIT;
          abort_pending_next = abort;
        end else if (abort) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (abort) abort_pending_next = 1'b1;
        if (read_valid) begin
          if (abort || abort_pending_reg) begin
            state_next = IDLE;
          end else begin
            data_next  = read_data;
            code_next  = read_code;
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        check_error = parity_error;
        stop_pass   = abort || (STOP_ON_ERROR && parity_error);
        pause_next  = '0;
        if (parity_error) begin
          error_valid_next   = 1'b1;
          error_address_next = address_reg;
        end
        if (address_reg == LAST_ADDRESS) begin
          address_next = '0;
          done_next    = !stop_pass;
          state_next   = (stop_pass || !continuous) ? IDLE : AFTER_CHECK;
        end else begin
          address_next = address_reg + ADDRESS_WIDTH'(1);
          state_next   = stop_pass ? IDLE : AFTER_CHECK;
        end
      end
      PAUSE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pause_reg == PAUSE_LAST) begin
          state_next = REQUEST;
        end else begin
          pause_next = pause_reg + PAUSE_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Clearing wins over the old value, but an error found in the same cycle still counts.
    if (clear_count) begin
      count_next = check_error ? COUNT_WIDTH'(1) : '0;
    end else if (check_error && count_reg != COUNT_MAX) begin
      count_next = count_reg + COUNT_WIDTH'(1);
    end
  end

  assign busy          = state_reg != IDLE;
  assign read_request  = state_reg == REQUEST;
  assign read_address  = address_reg;
  assign done          = done_reg;
  assign error_valid   = error_valid_reg;
  assign error_address = error_address_reg;
  assign error_count   = count_reg;
endmodule
